// File: rtl/alu_arith_pipe_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for the pipelined arithmetic unit.
// master drives operations and result acceptance; slave is the unit itself.
interface alu_arith_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sat_en;
  logic [TAG_W-1:0] tag_in;
  logic             clr_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;
  logic [TAG_W-1:0] tag_out;
  logic             carry_flag;

  modport master (
    output in_valid, op, a, b, sat_en, tag_in, clr_carry, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n, tag_out, carry_flag
  );

  modport slave (
    input  in_valid, op, a, b, sat_en, tag_in, clr_carry, out_ready,
    output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n, tag_out, carry_flag
  );
endinterface

// File: rtl/alu_arith_pipe.sv
`timescale 1ns/1ps
// Two-stage pipelined add/subtract unit with an internal carry flag for
// multi-word chaining, optional signed saturation and valid/ready flow control.
module alu_arith_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LO_W  = WIDTH / 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arith_pipe_if.slave bus
);
  localparam int unsigned HI_W = WIDTH - LO_W;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_SBC = 3'd6;
  localparam logic [2:0] OP_NEG = 3'd7;

  logic             s1_valid;
  logic             s2_valid;
  logic             ready1;
  logic             ready2;
  logic             fire;
  logic             carry_flag;
  logic             cf_eff;

  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] bm;
  logic             ci;
  logic [LO_W:0]    lo_sum;
  logic [HI_W:0]    hi_sum0;
  logic [HI_W:0]    hi_sum1;
  logic [WIDTH:0]   sum;

  logic [WIDTH:0]   s1_sum;
  logic             s1_a_msb;
  logic             s1_bm_msb;
  logic             s1_sat;
  logic             s1_cmp;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_v_c;
  logic [WIDTH-1:0] s2_res_c;
  logic             s2_z_c;
  logic             s2_n_c;

  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;
  logic [TAG_W-1:0] tag_out;

  assign ready2 = !s2_valid || bus.out_ready;
  assign ready1 = !s1_valid || ready2;
  assign fire   = bus.in_valid && ready1;

  // A clear in the same cycle as an op hides the old carry from that op
  assign cf_eff = carry_flag && !bus.clr_carry;

  // Operand steering: every op reduces to eff_a + bm + ci
  always_comb begin
    eff_a = bus.a;
    bm    = bus.b;
    ci    = 1'b0;
    case (bus.op)
      OP_ADD: ;
      OP_SUB, OP_CMP: begin
        bm = ~bus.b;
        ci = 1'b1;
      end
      OP_INC: begin
        bm = '0;
        ci = 1'b1;
      end
      OP_DEC: bm = '1;
      OP_ADC: ci = cf_eff;
      OP_SBC: begin
        bm = ~bus.b;
        ci = cf_eff;
      end
      OP_NEG: begin
        eff_a = '0;
        bm    = ~bus.a;
        ci    = 1'b1;
      end
      default: ;
    endcase
  end

  // Ripple low half; upper half precomputes both carry-in cases and selects
  always_comb begin
    lo_sum  = {1'b0, eff_a[LO_W-1:0]} + {1'b0, bm[LO_W-1:0]} + (LO_W+1)'(ci);
    hi_sum0 = {1'b0, eff_a[WIDTH-1:LO_W]} + {1'b0, bm[WIDTH-1:LO_W]};
    hi_sum1 = {1'b0, eff_a[WIDTH-1:LO_W]} + {1'b0, bm[WIDTH-1:LO_W]} + (HI_W+1)'(1'b1);
    sum     = lo_sum[LO_W] ? {hi_sum1, lo_sum[LO_W-1:0]} : {hi_sum0, lo_sum[LO_W-1:0]};
  end

  // Flag derivation and saturation from the stage-1 sum
  always_comb begin
    s2_v_c   = (s1_a_msb == s1_bm_msb) && (s1_sum[WIDTH-1] != s1_a_msb);
    s2_res_c = s1_sum[WIDTH-1:0];
    if (s1_sat && s2_v_c) begin
      s2_res_c = s1_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
    s2_z_c = (s2_res_c == '0);
    s2_n_c = s2_res_c[WIDTH-1];
    if (s1_cmp) begin
      s2_z_c   = (s1_sum[WIDTH-1:0] == '0);
      s2_n_c   = s1_sum[WIDTH-1];
      s2_res_c = '0;
    end
  end

  // Carry flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
    end else if (fire) begin
      carry_flag <= sum[WIDTH];
    end else if (bus.clr_carry) begin
      carry_flag <= 1'b0;
    end
  end

  // Stage 1: registered raw sum plus what stage 2 needs for flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_a_msb  <= 1'b0;
      s1_bm_msb <= 1'b0;
      s1_sat    <= 1'b0;
      s1_cmp    <= 1'b0;
      s1_tag    <= '0;
    end else if (ready1) begin
      s1_valid <= bus.in_valid;
      if (fire) begin
        s1_sum    <= sum;
        s1_a_msb  <= eff_a[WIDTH-1];
        s1_bm_msb <= bm[WIDTH-1];
        s1_sat    <= bus.sat_en;
        s1_cmp    <= (bus.op == OP_CMP);
        s1_tag    <= bus.tag_in;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      tag_out  <= '0;
    end else if (ready2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result  <= s2_res_c;
        flag_c  <= s1_sum[WIDTH];
        flag_v  <= s2_v_c;
        flag_z  <= s2_z_c;
        flag_n  <= s2_n_c;
        tag_out <= s1_tag;
      end
    end
  end

  assign bus.in_ready   = ready1;
  assign bus.out_valid  = s2_valid;
  assign bus.result     = result;
  assign bus.flag_c     = flag_c;
  assign bus.flag_v     = flag_v;
  assign bus.flag_z     = flag_z;
  assign bus.flag_n     = flag_n;
  assign bus.tag_out    = tag_out;
  assign bus.carry_flag = carry_flag;
endmodule

// File: tb/tb_alu_arith_pipe.sv
`timescale 1ns/1ps
// Bench for alu_arith_pipe: directed ops checked against a signed/unsigned
// arithmetic model and a fire-order queue, plus literal expectations per op.
module tb_alu_arith_pipe;
  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;
  localparam int SMAX = 32767;
  localparam int SMIN = -32768;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, INC = 3'd2, DEC = 3'd3;
  localparam logic [2:0] CMP = 3'd4, ADC = 3'd5, SBC = 3'd6, NEG = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arith_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus();
  alu_arith_pipe #(.WIDTH(W), .LO_W(W/2), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic          c, v, z, n;
    logic [TW-1:0] tag;
    longint        cyc;
    logic [W-1:0]  lres;
    logic [3:0]    lflg;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  longint     cyc = 0;
  bit         m_carry = 1'b0;
  logic [W-1:0] lit_res = '0;
  logic [3:0]   lit_flg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic intent of each op on plain integers
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit sat, input bit cf);
    exp_t e;
    int sa, sb, ua, ub, ic, t;
    logic [31:0] tv;
    bit c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    ic = int'(cf);
    t  = 0;
    c  = 1'b0;
    case (op)
      ADD:      begin t = sa + sb;          c = (ua + ub) >= 65536;      end
      SUB, CMP: begin t = sa - sb;          c = (ua >= ub);              end
      INC:      begin t = sa + 1;           c = (ua == 65535);           end
      DEC:      begin t = sa - 1;           c = (ua != 0);               end
      ADC:      begin t = sa + sb + ic;     c = (ua + ub + ic) >= 65536; end
      SBC:      begin t = sa - sb - 1 + ic; c = (ua + ic) > ub;          end
      default:  begin t = -sa;              c = (ua == 0);               end
    endcase
    tv    = t;
    e.c   = c;
    e.v   = (t > SMAX) || (t < SMIN);
    e.res = tv[W-1:0];
    if (sat && e.v) e.res = (t > 0) ? 16'h7FFF : 16'h8000;
    if (op == CMP) begin
      e.z   = (tv[W-1:0] == '0);
      e.n   = tv[W-1];
      e.res = '0;
    end else begin
      e.z = (e.res == '0);
      e.n = e.res[W-1];
    end
    e.tag  = '0;
    e.cyc  = 0;
    e.lres = '0;
    e.lflg = '0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model queue
  always @(negedge clk) begin : mon
    exp_t e;
    bit   exp_rdy;
    bit   exp_ov;
    if (!rst_n) begin
      q.delete();
      m_carry = 1'b0;
    end else begin
      chk("carry_flag", 32'(bus.carry_flag), 32'(m_carry));
      exp_rdy = (q.size() < 2) || bus.out_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      exp_ov = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (bus.out_valid && q.size() > 0) begin
        e = q[0];
        chk("result",  32'(bus.result),  32'(e.res));
        chk("flag_c",  32'(bus.flag_c),  32'(e.c));
        chk("flag_v",  32'(bus.flag_v),  32'(e.v));
        chk("flag_z",  32'(bus.flag_z),  32'(e.z));
        chk("flag_n",  32'(bus.flag_n),  32'(e.n));
        chk("tag_out", 32'(bus.tag_out), 32'(e.tag));
        if (bus.out_ready) begin
          chk("model_result", 32'(e.res), 32'(e.lres));
          chk("model_flags",  32'({e.c, e.v, e.z, e.n}), 32'(e.lflg));
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = model(bus.op, bus.a, bus.b, bus.sat_en, m_carry && !bus.clr_carry);
        e.tag  = bus.tag_in;
        e.cyc  = cyc;
        e.lres = lit_res;
        e.lflg = lit_flg;
        q.push_back(e);
        m_carry = e.c;
      end else if (bus.clr_carry) begin
        m_carry = 1'b0;
      end
    end
  end

  // Offer one op and hold it until accepted; flags literal is {C,V,Z,N}
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sat, input logic [TW-1:0] tag, input bit clr,
                      input logic [W-1:0] lres, input logic [3:0] lflg);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.sat_en   = sat;
    bus.tag_in   = tag;
    bus.clr_carry = clr;
    lit_res      = lres;
    lit_flg      = lflg;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("send_accept", 32'(acc), 32'd1);
    bus.in_valid  = 1'b0;
    bus.clr_carry = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.sat_en    = 1'b0;
    bus.tag_in    = '0;
    bus.clr_carry = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    32'(bus.result),    32'd0);
    chk("rst_carry",     32'(bus.carry_flag), 32'd0);
    chk("rst_tag_out",   32'(bus.tag_out),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overflow with and without saturation
    send(ADD, 16'h7FFF, 16'h0001, 1'b0, 4'h1, 1'b0, 16'h8000, 4'b0101);
    send(ADD, 16'h7FFF, 16'h0001, 1'b1, 4'h2, 1'b0, 16'h7FFF, 4'b0100);
    // Borrow and compare
    send(SUB, 16'h0003, 16'h0005, 1'b0, 4'h3, 1'b0, 16'hFFFE, 4'b0001);
    send(CMP, 16'h1234, 16'h1234, 1'b0, 4'h4, 1'b0, 16'h0000, 4'b1010);
    // Carry chaining, clear with op, clear alone, SBC
    send(ADD, 16'hFFFF, 16'h0001, 1'b0, 4'h5, 1'b0, 16'h0000, 4'b1010);
    send(ADC, 16'h0000, 16'h0000, 1'b0, 4'h6, 1'b0, 16'h0001, 4'b0000);
    send(ADD, 16'hFFFF, 16'h0001, 1'b0, 4'h7, 1'b0, 16'h0000, 4'b1010);
    send(ADC, 16'h0000, 16'h0000, 1'b0, 4'h8, 1'b1, 16'h0000, 4'b0010);
    send(SBC, 16'h0005, 16'h0003, 1'b0, 4'h9, 1'b0, 16'h0001, 4'b1000);
    send(ADC, 16'h0001, 16'h0001, 1'b0, 4'hA, 1'b0, 16'h0003, 4'b0000);
    send(ADD, 16'hFFFF, 16'h0001, 1'b0, 4'hB, 1'b0, 16'h0000, 4'b1010);
    bus.clr_carry = 1'b1;
    @(posedge clk);
    #1 bus.clr_carry = 1'b0;
    send(ADC, 16'h0000, 16'h0000, 1'b0, 4'hC, 1'b0, 16'h0000, 4'b0010);
    drain();

    // Backpressure: two held, third waits, in-order release
    bus.out_ready = 1'b0;
    fork
      begin
        send(ADD, 16'h0001, 16'h0001, 1'b0, 4'h1, 1'b0, 16'h0002, 4'b0000);
        send(SUB, 16'h000A, 16'h0003, 1'b0, 4'h2, 1'b0, 16'h0007, 4'b1000);
        send(INC, 16'h0007, 16'h0000, 1'b0, 4'h3, 1'b0, 16'h0008, 4'b0000);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_tag_out",  32'(bus.tag_out),  32'd1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Boundary ops
    send(DEC, 16'h8000, 16'h0000, 1'b0, 4'h4, 1'b0, 16'h7FFF, 4'b1100);
    send(DEC, 16'h8000, 16'h0000, 1'b1, 4'h5, 1'b0, 16'h8000, 4'b1101);
    send(INC, 16'hFFFF, 16'h0000, 1'b0, 4'h6, 1'b0, 16'h0000, 4'b1010);
    send(NEG, 16'h0000, 16'h1234, 1'b0, 4'h7, 1'b0, 16'h0000, 4'b1010);
    send(NEG, 16'h8000, 16'h0000, 1'b0, 4'h8, 1'b0, 16'h8000, 4'b0101);
    drain();

    // Asynchronous reset with ops in flight and carry set
    send(ADD, 16'hFFFF, 16'h0001, 1'b0, 4'h9, 1'b0, 16'h0000, 4'b1010);
    drain();
    bus.out_ready = 1'b0;
    send(ADD, 16'hFFFF, 16'hFFFF, 1'b0, 4'hA, 1'b0, 16'hFFFE, 4'b1001);
    send(ADD, 16'hFFFF, 16'hFFFF, 1'b0, 4'hB, 1'b0, 16'hFFFE, 4'b1001);
    chk("pre_rst_carry",     32'(bus.carry_flag), 32'd1);
    chk("pre_rst_out_valid", 32'(bus.out_valid),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid),  32'd0);
    chk("async_carry",     32'(bus.carry_flag), 32'd0);
    chk("async_result",    32'(bus.result),     32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(ADC, 16'h0005, 16'h0005, 1'b0, 4'hC, 1'b0, 16'h000A, 4'b0000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
